// File: rtl/grayscale_pkg.sv
// Shared grayscale constants, channel expansion helpers and pipeline bundles.
// Used by rgb565_gray_packer and the grayscale custom instruction.
package grayscale_pkg;

  localparam int unsigned W_R = 54;
  localparam int unsigned W_G = 183;
  localparam int unsigned W_B = 19;
  localparam int unsigned GRAY_SHIFT = 8;
  localparam int unsigned LANES = 4;
  localparam int FIFO_DEPTH_LOG2_DEF = 4;

  typedef struct packed {
    logic        vld;
    logic        sof;
    logic        eof;
    logic [15:0] pr;
    logic [15:0] pg;
    logic [15:0] pb;
  } s1_t;

  typedef struct packed {
    logic       vld;
    logic       sof;
    logic       eof;
    logic [7:0] gray;
  } s2_t;

  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

endpackage

// File: rtl/gray_word_fifo.sv
// Synchronous word FIFO (data + last) with occupancy level output.
// A write while full is taken only when a read happens on the same edge.
module gray_word_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH = 33
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic                  rd_valid,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign full     = (level == (DEPTH_LOG2+1)'(DEPTH));
  assign rd_valid = (level != '0);
  assign do_rd    = rd_en & rd_valid;
  assign do_wr    = wr_en & (~full | do_rd);
  // Head is forced to zero when empty so the outputs are clean after reset.
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rgb565_gray_packer.sv
// RGB565 -> 8-bit gray, packed four per word into a drain FIFO.
// RGB565_GRAY_PACKER_DROP_COUNT_EN adds a saturating dropCount output.
module rgb565_gray_packer
  import grayscale_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     pixelValid,
  input  logic [15:0]              pixelData,
  input  logic                     frameStart,
  input  logic                     frameEnd,
  input  logic                     clearOverflow,
  output logic                     wordValid,
  output logic [31:0]              wordData,
  output logic                     wordLast,
  input  logic                     wordReady,
  output logic [FIFO_DEPTH_LOG2:0] fifoLevel,
  output logic                     overflow
`ifdef RGB565_GRAY_PACKER_DROP_COUNT_EN
  ,
  output logic [15:0]              dropCount
`endif
);

  logic        accept;
  s1_t         s1_d, s1_q;
  s2_t         s2_d, s2_q;
  logic [15:0] sum;
  logic [1:0]  lane_q;
  logic [1:0]  lane_eff;
  logic [23:0] word_q;
  logic [31:0] word_c;
  logic        push;
  logic        pop;
  logic        full;
  logic        drop;
  logic [32:0] head;

  assign accept = pixelValid & enable;

  always_comb begin
    s1_d     = '0;
    s1_d.vld = accept;
    s1_d.sof = accept & frameStart;
    s1_d.eof = accept & frameEnd;
    s1_d.pr  = 16'(W_R) * {8'd0, expand5(pixelData[15:11])};
    s1_d.pg  = 16'(W_G) * {8'd0, expand6(pixelData[10:5])};
    s1_d.pb  = 16'(W_B) * {8'd0, expand5(pixelData[4:0])};
  end

  // Weights sum to 256, so the 16-bit sum never wraps.
  assign sum = s1_q.pr + s1_q.pg + s1_q.pb;

  always_comb begin
    s2_d      = '0;
    s2_d.vld  = s1_q.vld;
    s2_d.sof  = s1_q.sof;
    s2_d.eof  = s1_q.eof;
    s2_d.gray = 8'(sum >> GRAY_SHIFT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // frameStart throws away any partial word and restarts at lane 0.
  always_comb begin
    lane_eff = s2_q.sof ? 2'd0 : lane_q;
    word_c   = s2_q.sof ? 32'd0 : {8'd0, word_q};
    unique case (lane_eff)
      2'd0:    word_c[7:0]   = s2_q.gray;
      2'd1:    word_c[15:8]  = s2_q.gray;
      2'd2:    word_c[23:16] = s2_q.gray;
      default: word_c[31:24] = s2_q.gray;
    endcase
    push = s2_q.vld & ((lane_eff == 2'(LANES-1)) | s2_q.eof);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lane_q <= '0;
      word_q <= '0;
    end else if (s2_q.vld) begin
      if (push) begin
        lane_q <= '0;
        word_q <= '0;
      end else begin
        lane_q <= 2'(lane_eff + 2'd1);
        word_q <= word_c[23:0];
      end
    end
  end

  assign pop  = wordValid & wordReady;
  assign drop = push & full & ~pop;

  gray_word_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (33)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (push),
    .wr_data  ({s2_q.eof, word_c}),
    .rd_en    (wordReady),
    .rd_valid (wordValid),
    .rd_data  (head),
    .level    (fifoLevel),
    .full     (full)
  );

  assign {wordLast, wordData} = head;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)              overflow <= 1'b0;
    else if (drop)          overflow <= 1'b1;
    else if (clearOverflow) overflow <= 1'b0;
  end

`ifdef RGB565_GRAY_PACKER_DROP_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   dropCount <= '0;
    else if (clearOverflow)      dropCount <= {15'd0, drop};
    else if (drop && dropCount != 16'hFFFF)
      dropCount <= dropCount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_rgb565_gray_packer.sv
// Directed + randomized bench for rgb565_gray_packer with a
// transaction-level packing model and output scoreboard.
module tb_rgb565_gray_packer;

  logic        clock = 0;
  logic        reset = 1;
  logic        enable = 1;
  logic        pixelValid = 0;
  logic [15:0] pixelData = 0;
  logic        frameStart = 0;
  logic        frameEnd = 0;
  logic        clearOverflow = 0;
  logic        wordValid;
  logic [31:0] wordData;
  logic        wordLast;
  logic        wordReady = 0;
  logic [4:0]  fifoLevel;
  logic        overflow;
`ifdef RGB565_GRAY_PACKER_DROP_COUNT_EN
  logic [15:0] dropCount;
`endif

  int tests = 0;
  int fails = 0;

  logic [32:0] got[$];
  logic [32:0] exp_q[$];
  int          lanes[4];
  int          m_n = 0;
  int          m_drops = 0;
  bit          stalled = 0;

  always #5 clock = ~clock;

  rgb565_gray_packer dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .pixelValid    (pixelValid),
    .pixelData     (pixelData),
    .frameStart    (frameStart),
    .frameEnd      (frameEnd),
    .clearOverflow (clearOverflow),
    .wordValid     (wordValid),
    .wordData      (wordData),
    .wordLast      (wordLast),
    .wordReady     (wordReady),
    .fifoLevel     (fifoLevel),
    .overflow      (overflow)
`ifdef RGB565_GRAY_PACKER_DROP_COUNT_EN
    ,
    .dropCount     (dropCount)
`endif
  );

  always @(negedge clock)
    if (!reset && wordValid && wordReady)
      got.push_back({wordLast, wordData});

  task automatic chk(input string tag, input logic [32:0] obs,
                     input logic [32:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int gray_ref(input int d);
    int r, g, b, r8, g8, b8;
    r = (d >> 11) & 31;
    g = (d >> 5) & 63;
    b = d & 31;
    r8 = r * 8 + r / 4;
    g8 = g * 4 + g / 16;
    b8 = b * 8 + b / 4;
    return (54 * r8 + 183 * g8 + 19 * b8) / 256;
  endfunction

  task automatic model_beat(input int d, input bit fs, input bit fe);
    logic [31:0] w;
    if (fs) m_n = 0;
    lanes[m_n] = gray_ref(d);
    m_n++;
    if (m_n == 4 || fe) begin
      w = 0;
      for (int i = 0; i < m_n; i++) w |= 32'(lanes[i]) << (8 * i);
      if (stalled && exp_q.size() >= 16) m_drops++;
      else exp_q.push_back({fe, w});
      m_n = 0;
    end
  endtask

  task automatic beat(input logic v, input logic en, input logic [15:0] d,
                      input logic fs, input logic fe);
    pixelValid = v;
    enable = en;
    pixelData = d;
    frameStart = fs;
    frameEnd = fe;
    @(posedge clock); #1;
    if (v && en) model_beat(int'(d), fs, fe);
    pixelValid = 0;
    frameStart = 0;
    frameEnd = 0;
    enable = 1;
  endtask

  task automatic drain();
    int k;
    repeat (4) @(posedge clock);
    #1;
    wordReady = 1;
    k = 0;
    while (wordValid && k < 200) begin
      @(posedge clock); #1;
      k++;
    end
    chk("drain_done", {32'd0, wordValid}, 33'd0);
  endtask

  task automatic check_queue(input string tag);
    chk({tag, "_count"}, 33'(got.size()), 33'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk({tag, "_word"}, got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {32'd0, wordValid}, 33'd0);
    chk({tag, "_data"}, {1'b0, wordData}, 33'd0);
    chk({tag, "_last"}, {32'd0, wordLast}, 33'd0);
    chk({tag, "_level"}, 33'(fifoLevel), 33'd0);
    chk({tag, "_ovf"}, {32'd0, overflow}, 33'd0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 0;
    wordReady = 1;
    @(posedge clock); #1;

    // Four white pixels, check latency and value.
    for (int i = 0; i < 4; i++) beat(1, 1, 16'hFFFF, 0, 0);
    @(posedge clock); #1;
    chk("lat_early", {32'd0, wordValid}, 33'd0);
    @(posedge clock); #1;
    chk("lat_valid", {32'd0, wordValid}, 33'd1);
    chk("lat_data", {wordLast, wordData}, {1'b0, 32'hFFFFFFFF});
    drain();
    check_queue("white");

    // Primary colours.
    beat(1, 1, 16'hF800, 0, 0);
    beat(1, 1, 16'h07E0, 0, 0);
    beat(1, 1, 16'h001F, 0, 0);
    beat(1, 1, 16'h0000, 0, 0);
    drain();
    if (got.size() > 0) chk("rgb_const", got[0], {1'b0, 32'h0012B635});
    check_queue("rgb");

    // frameEnd on a partial word.
    for (int i = 0; i < 6; i++) beat(1, 1, 16'hFFFF, 0, i == 5);
    drain();
    if (got.size() == 2) chk("eof_const", got[1], {1'b1, 32'h0000FFFF});
    check_queue("eof");

    // Overflow with the consumer stalled.
    wordReady = 0;
    stalled = 1;
    m_drops = 0;
    for (int i = 0; i < 68; i++) beat(1, 1, 16'h0000, 0, 0);
    repeat (4) @(posedge clock);
    #1;
    chk("ovf_level", 33'(fifoLevel), 33'(exp_q.size()));
    chk("ovf_flag", {32'd0, overflow}, {32'd0, m_drops != 0});
    chk("ovf_drops", 33'(m_drops), 33'd1);
`ifdef RGB565_GRAY_PACKER_DROP_COUNT_EN
    chk("drop_count", 33'(dropCount), 33'(m_drops));
`endif
    stalled = 0;
    drain();
    check_queue("ovf");
    chk("ovf_sticky", {32'd0, overflow}, 33'd1);
    clearOverflow = 1;
    @(posedge clock); #1;
    clearOverflow = 0;
    chk("ovf_clear", {32'd0, overflow}, 33'd0);
`ifdef RGB565_GRAY_PACKER_DROP_COUNT_EN
    chk("drop_clear", 33'(dropCount), 33'd0);
`endif

    // frameStart discards a partial word.
    beat(1, 1, 16'h1234, 0, 0);
    beat(1, 1, 16'h4321, 0, 0);
    for (int i = 0; i < 4; i++) beat(1, 1, 16'hFFFF, i == 0, 0);
    drain();
    chk("sof_only", 33'(got.size()), 33'd1);
    check_queue("sof");

    // Randomized frames with a random consumer.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 14; i++) begin
        wordReady = 1'($urandom_range(0, 1));
        beat(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0),
             16'($urandom), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 5) == 0));
      end
      drain();
      check_queue("rand");
    end

    // Reset mid-word with three words queued.
    wordReady = 0;
    for (int i = 0; i < 14; i++) beat(1, 1, 16'($urandom), 0, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("pre_rst_level", 33'(fifoLevel), 33'd3);
    reset = 1;
    @(posedge clock); #1;
    check_reset_outputs("mid_rst");
    reset = 0;
    got.delete();
    exp_q.delete();
    m_n = 0;
    @(posedge clock); #1;
    beat(1, 1, 16'hF800, 1, 0);
    beat(1, 1, 16'h07E0, 0, 0);
    beat(1, 1, 16'h001F, 0, 0);
    beat(1, 1, 16'h0000, 0, 1);
    drain();
    if (got.size() > 0) chk("post_rst_const", got[0], {1'b1, 32'h0012B635});
    check_queue("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
